// File: rtl/rv32i_types.sv
// Shared RV32I type definitions used across the writeback datapath.
package rv32i_types;

   // Writeback result format selected by the producing unit.
   typedef enum logic [2:0] {
      WB_WORD   = 3'd0,
      WB_BYTE   = 3'd1,
      WB_BYTE_U = 3'd2,
      WB_HALF   = 3'd3,
      WB_HALF_U = 3'd4
   } wb_fmt_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-channel writeback queue. Pointers carry an extra wrap bit so full and
// empty are distinguished without a separate count.
module wb_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = mem[rd_ptr[AW-1:0]];

   // Pointer advance on accepted push / pop; reset empties the queue.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop && !empty)
            rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Entry storage; contents are meaningless while empty, so no reset.
   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: queues results from several producers, grants one head
// per cycle round-robin, formats it and drives the register-file write port.
module wb_arbiter
   import rv32i_types::*;
#(
   parameter int NUM_CH = 2,
   parameter int DEPTH  = 2,
   parameter int XLEN   = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CH-1:0]           ch_valid,
   output logic [NUM_CH-1:0]           ch_ready,
   input  logic [NUM_CH-1:0][4:0]      ch_rd,
   input  wb_fmt_t                     ch_fmt [NUM_CH],
   input  logic [NUM_CH-1:0][1:0]      ch_offset,
   input  logic [NUM_CH-1:0][XLEN-1:0] ch_data,
   output logic [XLEN-1:0]             regfile_in,
   output logic [4:0]                  rd_out,
   output logic                        load_regfile,
   output logic                        misalign_err,
   output logic                        busy
);

   // Entry layout: {rd, fmt, offset, data}
   localparam int ENT_W = XLEN + 10;
   localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [ENT_W-1:0]  head [NUM_CH];
   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] empty;
   logic [NUM_CH-1:0] pop;

   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  gnt_idx_p0;
   logic [PTR_W-1:0]  next_ptr_p0;
   logic              gnt_vld_p0;
   logic [ENT_W-1:0]  sel_p0;
   logic [4:0]        sel_rd_p0;
   wb_fmt_t           sel_fmt_p0;
   logic [1:0]        sel_off_p0;
   logic [XLEN-1:0]   sel_data_p0;
   logic              mis_p0;
   logic [XLEN-1:0]   wr_data_p0;
   logic              vld_p1;

   function automatic logic is_misaligned(input wb_fmt_t fmt, input logic [1:0] off);
      case (fmt)
         WB_WORD:            return (off != 2'd0);
         WB_HALF, WB_HALF_U: return (off == 2'd3);
         default:            return 1'b0;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] format_data(input wb_fmt_t fmt, input logic [1:0] off,
                                                   input logic [XLEN-1:0] data);
      logic [XLEN-1:0] sh;
      sh = data >> {off, 3'b000};
      case (fmt)
         WB_BYTE:   return {{(XLEN-8){sh[7]}}, sh[7:0]};
         WB_BYTE_U: return {{(XLEN-8){1'b0}}, sh[7:0]};
         WB_HALF:   return {{(XLEN-16){sh[15]}}, sh[15:0]};
         WB_HALF_U: return {{(XLEN-16){1'b0}}, sh[15:0]};
         default:   return data;
      endcase
   endfunction

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      // ready depends only on occupancy, never on the same-cycle pop
      assign ch_ready[g] = !full[g] && !rst;

      wb_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (ch_valid[g] && ch_ready[g]),
         .din   ({ch_rd[g], ch_fmt[g], ch_offset[g], ch_data[g]}),
         .pop   (pop[g]),
         .dout  (head[g]),
         .full  (full[g]),
         .empty (empty[g])
      );
   end

   // ---- p0: round-robin grant over pre-edge FIFO heads, then format ----
   // Round-robin search starting at rr_ptr; first non-empty head wins.
   always_comb begin
      gnt_vld_p0 = 1'b0;
      gnt_idx_p0 = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!gnt_vld_p0 && !empty[(int'(rr_ptr) + i) % NUM_CH]) begin
            gnt_vld_p0 = 1'b1;
            gnt_idx_p0 = PTR_W'((int'(rr_ptr) + i) % NUM_CH);
         end
      end
   end

   // One-hot pop of the granted channel.
   always_comb begin
      pop = '0;
      if (gnt_vld_p0)
         pop[gnt_idx_p0] = 1'b1;
   end

   assign next_ptr_p0 = (int'(gnt_idx_p0) == NUM_CH - 1) ? '0 : gnt_idx_p0 + PTR_W'(1);
   assign sel_p0      = head[gnt_idx_p0];
   assign sel_data_p0 = sel_p0[XLEN-1:0];
   assign sel_off_p0  = sel_p0[XLEN +: 2];
   assign sel_fmt_p0  = wb_fmt_t'(sel_p0[XLEN+2 +: 3]);
   assign sel_rd_p0   = sel_p0[XLEN+5 +: 5];
   assign mis_p0      = gnt_vld_p0 && is_misaligned(sel_fmt_p0, sel_off_p0);
   assign wr_data_p0  = format_data(sel_fmt_p0, sel_off_p0, sel_data_p0);

   // ---- p1: registered write port ----
   // Register the granted result; idle cycles hold data/rd and drop strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr       <= '0;
         regfile_in   <= '0;
         rd_out       <= '0;
         load_regfile <= 1'b0;
         misalign_err <= 1'b0;
         vld_p1       <= 1'b0;
      end else begin
         vld_p1       <= gnt_vld_p0;
         load_regfile <= gnt_vld_p0 && !mis_p0 && (sel_rd_p0 != 5'd0);
         misalign_err <= mis_p0;
         if (gnt_vld_p0) begin
            rr_ptr     <= next_ptr_p0;
            rd_out     <= sel_rd_p0;
            regfile_in <= mis_p0 ? '0 : wr_data_p0;
         end
      end
   end

   assign busy = !(&empty) || vld_p1;

endmodule
